// File: rtl/tdm_demux_8ch_if.sv
// Bundle of the serial TDM input stream and the demultiplexed frame/channel outputs.
// master drives the stream (source side), slave is the demultiplexer.
interface tdm_demux_8ch_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   dataIn;
  logic               dataValid;
  logic               frameSync;
  logic [8*WIDTH-1:0] dataOut;
  logic               frameValid;
  logic [7:0]         chanStrobe;
  logic [WIDTH-1:0]   chanData;
  logic               locked;
  logic               syncError;

  modport master (
    output dataIn, dataValid, frameSync,
    input  dataOut, frameValid, chanStrobe, chanData, locked, syncError
  );

  modport slave (
    input  dataIn, dataValid, frameSync,
    output dataOut, frameValid, chanStrobe, chanData, locked, syncError
  );
endinterface

// File: rtl/tdm_demux_8ch.sv
// 1:8 TDM demultiplexer with hunt/lock frame alignment; one sample per cycle, all outputs
// registered, a completed frame appears on dataOut the edge its slot-7 sample is accepted.
module tdm_demux_8ch #(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  tdm_demux_8ch_if.slave        bus
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

  logic [0:0]       state;
  logic [2:0]       slot;
  logic [3:0]       miss;
  logic [WIDTH-1:0] shadow [0:6];

  assign bus.locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HUNT;
      slot           <= 3'd0;
      miss           <= 4'd0;
      bus.dataOut    <= '0;
      bus.frameValid <= 1'b0;
      bus.chanStrobe <= 8'd0;
      bus.chanData   <= '0;
      bus.syncError  <= 1'b0;
      for (int k = 0; k < 7; k++) shadow[k] <= '0;
    end else begin
      bus.frameValid <= 1'b0;
      bus.chanStrobe <= 8'd0;
      bus.syncError  <= 1'b0;
      if (bus.dataValid) begin
        if (state == HUNT) begin
          if (bus.frameSync) begin
            shadow[0]      <= bus.dataIn;
            slot           <= 3'd1;
            miss           <= 4'd0;
            state          <= LOCK;
            bus.chanStrobe <= 8'h01;
            bus.chanData   <= bus.dataIn;
          end
        end else if (bus.frameSync && slot != 3'd0) begin
          // Misplaced sync: drop the partial frame and realign on this sample.
          bus.syncError  <= 1'b1;
          shadow[0]      <= bus.dataIn;
          slot           <= 3'd1;
          miss           <= 4'd0;
          bus.chanStrobe <= 8'h01;
          bus.chanData   <= bus.dataIn;
        end else if (slot == 3'd0 && !bus.frameSync && (miss + 4'd1) == MISS_LIM) begin
          state         <= HUNT;
          bus.syncError <= 1'b1;
          miss          <= 4'd0;
        end else begin
          // Flywheel: a slot-0 sample without sync is still stored while misses accumulate.
          if (slot == 3'd0) miss <= bus.frameSync ? 4'd0 : miss + 4'd1;
          if (slot == 3'd7) begin
            for (int k = 0; k < 7; k++) bus.dataOut[k*WIDTH +: WIDTH] <= shadow[k];
            bus.dataOut[7*WIDTH +: WIDTH] <= bus.dataIn;
            bus.frameValid <= 1'b1;
          end else begin
            shadow[slot] <= bus.dataIn;
          end
          bus.chanStrobe <= 8'd1 << slot;
          bus.chanData   <= bus.dataIn;
          slot           <= slot + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch: a WIDTH=4 instance plus a WIDTH=1 instance fed bit 0
// of the same stream, with hand-computed expectations for every step.
module tb_tdm_demux_8ch;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tdm_demux_8ch_if #(.WIDTH(4)) bus4 ();
  tdm_demux_8ch_if #(.WIDTH(1)) bus1 ();

  assign bus1.dataIn    = bus4.dataIn[0];
  assign bus1.dataValid = bus4.dataValid;
  assign bus1.frameSync = bus4.frameSync;

  tdm_demux_8ch #(.WIDTH(4), .MISS_LIMIT(3)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  tdm_demux_8ch #(.WIDTH(1), .MISS_LIMIT(3)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then look at the outputs 1 time unit after the edge.
  task automatic acc(input logic v, input logic s, input logic [3:0] d);
    bus4.dataValid = v;
    bus4.frameSync = s;
    bus4.dataIn    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    acc(1'b0, 1'b0, 4'h0);
    reset = 1'b0;
  endtask

  logic [7:0] bits;

  initial begin
    reset = 1'b0;
    bus4.dataValid = 1'b0;
    bus4.frameSync = 1'b0;
    bus4.dataIn    = 4'h0;
    #1;
    do_reset();
    chk("rst_dataOut", bus4.dataOut, 32'h0);
    chk("rst_frameValid", {31'd0, bus4.frameValid}, 32'd0);
    chk("rst_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
    chk("rst_chanData", {28'd0, bus4.chanData}, 32'd0);
    chk("rst_locked", {31'd0, bus4.locked}, 32'd0);
    chk("rst_syncError", {31'd0, bus4.syncError}, 32'd0);

    // Frame 1,0,1,1,0,0,1,0 back to back, sync on the first sample.
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      acc(1'b1, i == 0, {3'd0, bits[i]});
      chk("t1_strobe", {24'd0, bus4.chanStrobe}, 32'd1 << i);
      chk("t1_chanData", {28'd0, bus4.chanData}, {31'd0, bits[i]});
      chk("t1_locked", {31'd0, bus4.locked}, 32'd1);
      chk("t1_frameValid", {31'd0, bus4.frameValid}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t1_dataOut_w1", {24'd0, bus1.dataOut}, 32'h0000_004D);
    chk("t1_dataOut_w4", bus4.dataOut, 32'h0100_1101);
    chk("t1_w1_frameValid", {31'd0, bus1.frameValid}, 32'd1);
    acc(1'b0, 1'b0, 4'h0);
    chk("t1_fv_pulse", {31'd0, bus4.frameValid}, 32'd0);
    chk("t1_dataOut_hold", bus4.dataOut, 32'h0100_1101);

    // HUNT ignores unsynced samples.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      acc(1'b1, 1'b0, 4'h9);
      chk("t2_hunt_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
      chk("t2_hunt_locked", {31'd0, bus4.locked}, 32'd0);
    end
    // Sync locks; frame 0..7 with a 3-cycle gap between slots 3 and 4.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          acc(1'b0, 1'b1, 4'hE);
          chk("t3_gap_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
          chk("t3_gap_frameValid", {31'd0, bus4.frameValid}, 32'd0);
          chk("t3_gap_syncError", {31'd0, bus4.syncError}, 32'd0);
        end
      end
      acc(1'b1, i == 0, 4'(i));
      chk("t3_strobe", {24'd0, bus4.chanStrobe}, 32'd1 << i);
      chk("t3_locked", {31'd0, bus4.locked}, 32'd1);
      chk("t3_frameValid", {31'd0, bus4.frameValid}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t3_dataOut", bus4.dataOut, 32'h7654_3210);

    // Sync at slot 5: error, realign, that sample becomes channel 0.
    for (int i = 0; i < 5; i++) acc(1'b1, i == 0, 4'(8 + i));
    acc(1'b1, 1'b1, 4'hA);
    chk("t4_syncError", {31'd0, bus4.syncError}, 32'd1);
    chk("t4_strobe", {24'd0, bus4.chanStrobe}, 32'h01);
    chk("t4_frameValid", {31'd0, bus4.frameValid}, 32'd0);
    chk("t4_locked", {31'd0, bus4.locked}, 32'd1);
    chk("t4_dataOut_hold", bus4.dataOut, 32'h7654_3210);
    for (int i = 1; i < 8; i++) begin
      acc(1'b1, 1'b0, 4'(i));
      chk("t4_frameValid2", {31'd0, bus4.frameValid}, (i == 7) ? 32'd1 : 32'd0);
      chk("t4_noerr", {31'd0, bus4.syncError}, 32'd0);
    end
    chk("t4_dataOut", bus4.dataOut, 32'h7654_321A);

    // Three frames without sync at slot 0: two flywheel, third drops lock.
    for (int i = 0; i < 8; i++) acc(1'b1, 1'b0, 4'(i));
    chk("t5_fv1", {31'd0, bus4.frameValid}, 32'd1);
    chk("t5_dataOut1", bus4.dataOut, 32'h7654_3210);
    for (int i = 0; i < 8; i++) acc(1'b1, 1'b0, 4'(8 + i));
    chk("t5_fv2", {31'd0, bus4.frameValid}, 32'd1);
    chk("t5_dataOut2", bus4.dataOut, 32'hFEDC_BA98);
    chk("t5_locked2", {31'd0, bus4.locked}, 32'd1);
    acc(1'b1, 1'b0, 4'h3);
    chk("t5_syncError", {31'd0, bus4.syncError}, 32'd1);
    chk("t5_locked", {31'd0, bus4.locked}, 32'd0);
    chk("t5_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
    acc(1'b1, 1'b0, 4'h4);
    chk("t5_hunt_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
    chk("t5_err_pulse", {31'd0, bus4.syncError}, 32'd0);

    // Reset at slot 4 mid-frame, then a clean synced frame.
    for (int i = 0; i < 4; i++) acc(1'b1, i == 0, 4'h5);
    reset = 1'b1;
    acc(1'b1, 1'b1, 4'h5);
    reset = 1'b0;
    chk("t6_dataOut", bus4.dataOut, 32'h0);
    chk("t6_locked", {31'd0, bus4.locked}, 32'd0);
    chk("t6_strobe", {24'd0, bus4.chanStrobe}, 32'd0);
    chk("t6_chanData", {28'd0, bus4.chanData}, 32'd0);
    chk("t6_syncError", {31'd0, bus4.syncError}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      acc(1'b1, i == 0, 4'(2 * i + 1));
      chk("t6_chanData2", {28'd0, bus4.chanData}, 32'(2 * i + 1));
      chk("t6_frameValid", {31'd0, bus4.frameValid}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t6_dataOut2", bus4.dataOut, 32'hFDB9_7531);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Sequential 1-to-8 time-division demultiplexer, the receive-side counterpart of the team's 8:1 channel multiplexers. Accepts a framed stream of samples (slot 0 marked by `frameSync`), steers each sample to one of eight channel slots, and presents a complete frame atomically on a wide output bus. Tracks frame alignment with a hunt/lock state machine and flags sync errors.

## Interface
- `WIDTH`, 1: bits per channel sample.
- `MISS_LIMIT`, 3: consecutive frames with missing `frameSync` at slot 0 before lock is dropped (1..15).
- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `dataIn`  input  WIDTH  sample for the current slot.
- `dataValid`  input  1  `dataIn` carries a sample this cycle.
- `frameSync`  input  1  qualified by `dataValid`; marks the sample as slot 0.
- `dataOut`  output  8*WIDTH  last complete frame; channel k at bits [k*WIDTH +: WIDTH].
- `frameValid`  output  1  one-cycle pulse: `dataOut` just updated.
- `chanStrobe`  output  8  one-hot; bit k pulses one cycle after a slot-k sample is accepted.
- `chanData`  output  WIDTH  sample accompanying `chanStrobe`.
- `locked`  output  1  state is LOCK.
- `syncError`  output  1  one-cycle pulse on an alignment fault.

## Operation
- An accept is a cycle with `dataValid`=1; nothing advances otherwise.
- States:
  - HUNT (reset state): accepts without `frameSync` are ignored; no strobes. An accept with `frameSync` stores the sample as slot 0, sets slot counter to 1, and moves to LOCK.
  - LOCK: each accept is written to shadow slot `slot` and `slot` increments mod 8.
- Slot-0 accept in LOCK:
  - `frameSync`=1: miss counter clears.
  - `frameSync`=0: sample is still taken as slot 0 (flywheel) and the miss counter increments. When the counter reaches `MISS_LIMIT`: go to HUNT, pulse `syncError`, discard the sample, clear the counter.
- `frameSync`=1 on an accept in LOCK with slot≠0:
  - Pulse `syncError` and discard the partial frame; no `frameValid` for it.
  - The sample becomes the new slot 0, slot is set to 1, the miss counter clears, and the state stays LOCK.
- Slot-7 accept in LOCK: `dataOut` loads shadow slots 0..6 plus the incoming sample in one edge; `frameValid` pulses.
- `chanStrobe`/`chanData` fire for every sample stored (including HUNT→LOCK slot 0); never for discarded or ignored samples.
- `reset` mid-frame: partial frame discarded, `dataOut` cleared, state HUNT.

## Timing
- All outputs registered.
- Reset values: `dataOut`=0, `frameValid`=0, `chanStrobe`=0, `chanData`=0, `locked`=0, `syncError`=0, slot=0, miss counter=0.
- Per-sample latency: accept at edge N → `chanStrobe`/`chanData` valid after edge N, for one cycle.
- Frame latency: slot-7 accept at edge N → `dataOut` updated and `frameValid`=1 after edge N; `dataOut` holds until the next completed frame.
- `locked` changes after the same edge as the transition that causes it.
- Throughput: one sample per cycle sustained; back-to-back frames produce `frameValid` every 8 accepts.
- `dataValid` gaps of any length are allowed mid-frame; the slot counter holds.
- `frameSync` with `dataValid`=0 is ignored.
- Simultaneous events:
  - Mid-frame sync and a slot-7 position cannot coincide. Sync at slot 7 counts as mid-frame: error and resync, no `frameValid`.
  - `reset` overrides all other inputs.

## Test plan
- Reset, then WIDTH=1, 8 back-to-back accepts 1,0,1,1,0,0,1,0 with `frameSync` on the first → `locked`=1 after the first edge; `chanStrobe` walks 0x01..0x80; `dataOut`=8'b0100_1101 with a `frameValid` pulse after the 8th edge.
- Samples without `frameSync` while in HUNT → no strobes, `locked`=0. Then a sync → lock.
- WIDTH=4, frame 0..7 with `dataValid` dropping for 3 cycles between slots 3 and 4 → `dataOut`=32'h7654_3210, `frameValid` delayed by exactly 3 cycles.
- `frameSync` at slot 5 → `syncError` pulse, no `frameValid`; that sample becomes channel 0 of the next frame, whose `dataOut` is correct.
- MISS_LIMIT=3, three consecutive frames with no sync at slot 0 → the first two still produce `frameValid`; on the third slot-0 accept `syncError` pulses and `locked` drops.
- `reset` asserted at slot 4 of a frame → all outputs 0 next cycle. A subsequent full synced frame is delivered correctly with no stale data.
